// File: rtl/motor_pwm_sequencer.sv
// Four-channel motor PWM sequencer between the Nios PIO exports and the ESC pins.
// A free-running period counter loads a shadow period and per-channel duty
// targets at each end of period. Channels are held at idle duty while arming,
// slew-limited while running, and forced low when disarmed or faulted. A software
// watchdog counted in periods moves RUN to FAULT. FAULT is left only through stop.
module motor_pwm_sequencer #(
  parameter int CNT_W        = 32,
  parameter int MIN_PERIOD   = 1000,
  parameter int IDLE_DUTY    = 500,
  parameter int ARM_PERIODS  = 100,
  parameter int SLEW_STEP    = 50,
  parameter int WDOG_PERIODS = 50
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [CNT_W-1:0] period_in,
  input  logic [CNT_W-1:0] duty_1_in,
  input  logic [CNT_W-1:0] duty_2_in,
  input  logic [CNT_W-1:0] duty_3_in,
  input  logic [CNT_W-1:0] duty_4_in,
  input  logic [CNT_W-1:0] stop_in,
  input  logic             wdog_kick,
  output logic [3:0]       pwm_out,
  output logic             period_start,
  output logic [1:0]       state_out,
  output logic             fault_out
);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_RUN      = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] IDLE_D    = CNT_W'(IDLE_DUTY);
  localparam logic [CNT_W-1:0] STEP      = CNT_W'(SLEW_STEP);
  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_PERIODS - 1);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_PERIODS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] period_nxt;
  logic [CNT_W-1:0] arm_cnt, arm_nxt;
  logic [CNT_W-1:0] wd_cnt, wd_nxt;
  logic [CNT_W-1:0] duty_in  [4];
  logic [CNT_W-1:0] duty_tgt [4];
  logic [CNT_W-1:0] duty_act [4];
  logic [CNT_W-1:0] idle_duty;
  logic             eop;
  logic             period_ok;
  logic             live;
  logic             unused_stop_bits;

  assign duty_in[0] = duty_1_in;
  assign duty_in[1] = duty_2_in;
  assign duty_in[2] = duty_3_in;
  assign duty_in[3] = duty_4_in;

  // Only bit 0 of the stop export carries meaning.
  assign unused_stop_bits = ^stop_in[CNT_W-1:1];

  assign eop        = (cnt == period_sh - ONE);
  assign period_ok  = (period_in >= MIN_P);
  // An illegal request leaves the shadow period (and the duty clamp) untouched.
  assign period_nxt = period_ok ? period_in : period_sh;
  assign live       = (state == ST_ARMING) || (state == ST_RUN);
  assign idle_duty  = (IDLE_D < period_sh) ? IDLE_D : period_sh;

  assign state_out = state;
  assign fault_out = (state == ST_FAULT);

  // Move act toward tgt by at most STEP; compare first so nothing wraps.
  function automatic logic [CNT_W-1:0] slew(input logic [CNT_W-1:0] act,
                                            input logic [CNT_W-1:0] tgt);
    if (tgt > act) slew = ((tgt - act) > STEP) ? act + STEP : tgt;
    else           slew = ((act - tgt) > STEP) ? act - STEP : tgt;
  endfunction

  // Per-channel target: requested duty clamped to the period about to be used.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      duty_tgt[i] = (duty_in[i] < period_nxt) ? duty_in[i] : period_nxt;
    end
  end

  // Next state and arm/watchdog counters; stop and illegal period override last.
  always_comb begin
    state_nxt = state;
    arm_nxt   = arm_cnt;
    wd_nxt    = wd_cnt;
    case (state)
      ST_DISARMED: begin
        if (period_ok) begin
          state_nxt = ST_ARMING;
          arm_nxt   = '0;
        end
      end
      ST_ARMING: begin
        if (eop) begin
          arm_nxt = arm_cnt + ONE;
          if (arm_cnt == ARM_LAST) begin
            state_nxt = ST_RUN;
            wd_nxt    = '0;
          end
        end
      end
      ST_RUN: begin
        if (wdog_kick) begin
          wd_nxt = '0;
        end else if (eop) begin
          wd_nxt = wd_cnt + ONE;
          if (wd_cnt == WDOG_LAST) state_nxt = ST_FAULT;
        end
      end
      default: ;
    endcase
    if (live && !period_ok) state_nxt = ST_FAULT;
    if (stop_in[0])         state_nxt = ST_DISARMED;
  end

  // State register with arm and watchdog counters.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state   <= ST_DISARMED;
      arm_cnt <= '0;
      wd_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      arm_cnt <= arm_nxt;
      wd_cnt  <= wd_nxt;
    end
  end

  // Period counter, shadow period and registered start-of-period pulse.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      cnt          <= '0;
      period_sh    <= MIN_P;
      period_start <= 1'b0;
    end else begin
      period_start <= eop;
      if (eop) begin
        cnt       <= '0;
        period_sh <= period_nxt;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

  // Active duties change only at end of period, so a running pulse is never cut.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 4; i++) duty_act[i] <= '0;
    end else if (eop) begin
      for (int i = 0; i < 4; i++) begin
        case (state)
          ST_RUN:    duty_act[i] <= slew(duty_act[i], duty_tgt[i]);
          ST_ARMING: duty_act[i] <= idle_duty;
          default:   duty_act[i] <= '0;
        endcase
      end
    end
  end

  // Registered PWM pins, gated low outside ARMING and RUN.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < 4; i++) pwm_out[i] <= live && (cnt < duty_act[i]);
    end
  end

endmodule

// File: tb/tb_motor_pwm_sequencer.sv
// Bench for motor_pwm_sequencer: directed steps plus a random soak, with every
// output compared each cycle against a period-level behavioural model.
module tb_motor_pwm_sequencer;
  localparam int CW    = 16;
  localparam int MINP  = 10;
  localparam int IDLE  = 3;
  localparam int ARMP  = 3;
  localparam int STEP  = 2;
  localparam int WDOG  = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [CW-1:0] period_in;
  logic [CW-1:0] stop_in;
  logic [CW-1:0] duty_in [4];
  logic          kick;
  logic [3:0]    pwm_out;
  logic          period_start;
  logic [1:0]    state_out;
  logic          fault_out;

  motor_pwm_sequencer #(
    .CNT_W(CW), .MIN_PERIOD(MINP), .IDLE_DUTY(IDLE), .ARM_PERIODS(ARMP),
    .SLEW_STEP(STEP), .WDOG_PERIODS(WDOG)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .period_in(period_in),
    .duty_1_in(duty_in[0]), .duty_2_in(duty_in[1]), .duty_3_in(duty_in[2]),
    .duty_4_in(duty_in[3]), .stop_in(stop_in), .wdog_kick(kick),
    .pwm_out(pwm_out), .period_start(period_start), .state_out(state_out),
    .fault_out(fault_out)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] exp_q[$];

  // Reference model: phase 0 disarmed, 1 arming, 2 run, 3 fault.
  int m_cnt = 0, m_per = MINP, m_arm = 0, m_wd = 0, m_st = 0;
  int m_duty[4] = '{0, 0, 0, 0};
  logic [3:0] m_pwm = '0;
  logic       m_ps  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock edge of the model, from the inputs presented during the cycle.
  task automatic model_edge();
    bit eop, live;
    int nst, newper, tgt, d;
    if (!rst_n) begin
      m_cnt = 0; m_per = MINP; m_arm = 0; m_wd = 0; m_st = 0;
      for (int i = 0; i < 4; i++) m_duty[i] = 0;
      m_pwm = '0; m_ps = 1'b0;
      return;
    end
    eop  = (m_cnt == m_per - 1);
    live = (m_st == 1) || (m_st == 2);
    for (int i = 0; i < 4; i++) m_pwm[i] = live && (m_cnt < m_duty[i]);
    m_ps = eop;
    nst = m_st;
    if (stop_in[0]) nst = 0;
    else if (live && int'(period_in) < MINP) nst = 3;
    else if (m_st == 0 && int'(period_in) >= MINP) begin nst = 1; m_arm = 0; end
    else if (m_st == 1 && eop) begin
      m_arm++;
      if (m_arm == ARMP) begin nst = 2; m_wd = 0; end
    end else if (m_st == 2) begin
      if (kick) m_wd = 0;
      else if (eop) m_wd++;
      if (m_wd == WDOG) nst = 3;
    end
    if (eop) begin
      newper = (int'(period_in) >= MINP) ? int'(period_in) : m_per;
      for (int i = 0; i < 4; i++) begin
        tgt = (int'(duty_in[i]) < newper) ? int'(duty_in[i]) : newper;
        if (m_st == 2) begin
          d = tgt - m_duty[i];
          if (d > STEP) d = STEP;
          if (d < -STEP) d = -STEP;
          m_duty[i] += d;
        end else if (m_st == 1) m_duty[i] = (IDLE < m_per) ? IDLE : m_per;
        else m_duty[i] = 0;
      end
      m_per = newper;
      m_cnt = 0;
    end else m_cnt++;
    m_st = nst;
  endtask

  // Driver: one clock, model update, then compare all outputs off the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
    chk("period_start", 32'(period_start), 32'(m_ps));
    chk("state_out", 32'(state_out), m_st);
    chk("fault_out", 32'(fault_out), 32'(m_st == 3));
  endtask

  // Twenty cycles from a period start; counts high samples on one channel.
  task automatic run_period(input int kick_at, input int ch, output int hi);
    hi = 0;
    duty_in[2] = CW'($urandom_range(0, 30));
    duty_in[3] = CW'($urandom_range(0, 30));
    for (int k = 0; k < 20; k++) begin
      if (pwm_out[ch] === 1'b1) hi++;
      kick = (k == kick_at);
      tick();
      kick = 1'b0;
    end
  endtask

  task automatic wait_ps();
    int n = 0;
    while (period_start !== 1'b1 && n < 40) begin tick(); n++; end
    chk("wait_ps_timeout", 32'(period_start), 1);
  endtask

  initial begin
    int hi, first, second, n, r;
    rst_n = 1'b0; period_in = 20; stop_in = 1; kick = 1'b0;
    for (int i = 0; i < 4; i++) duty_in[i] = '0;
    repeat (3) tick();
    chk("rst_state", 32'(state_out), 0);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_fault", 32'(fault_out), 0);
    chk("rst_ps", 32'(period_start), 0);

    // Disarmed: outputs low, first period uses the reset shadow of 10.
    rst_n = 1'b1;
    first = -1; second = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk("t1_pwm", 32'(pwm_out), 0);
      chk("t1_state", 32'(state_out), 0);
      if (period_start === 1'b1) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    chk("t1_first_ps", first, 10);
    chk("t1_ps_gap", second - first, 20);

    // Arming then run with channel 1 slewing 3 -> 8.
    duty_in[0] = 8;
    duty_in[1] = CW'($urandom_range(0, 30));
    wait_ps();
    stop_in = 0;
    exp_q = '{8'd0, 8'd3, 8'd3, 8'd3, 8'd5, 8'd7, 8'd8, 8'd8};
    for (int w = 0; w < 8; w++) begin
      if (w == 2) chk("t2_arming", 32'(state_out), 1);
      if (w == 3) chk("t2_run", 32'(state_out), 2);
      run_period($urandom_range(0, 18), 0, hi);
      chk("t2_ch1_high", hi, 32'(exp_q.pop_front()));
    end

    // Channel 2 saturates high, then slews to constant low.
    duty_in[1] = 25;
    repeat (12) run_period($urandom_range(0, 18), 1, hi);
    run_period($urandom_range(0, 18), 1, hi);
    chk("t3_ch2_full", hi, 20);
    duty_in[1] = 0;
    repeat (12) run_period($urandom_range(0, 18), 1, hi);
    run_period($urandom_range(0, 18), 1, hi);
    chk("t3_ch2_zero", hi, 0);

    // Watchdog expiry, kick does not clear FAULT, stop does.
    run_period(5, 0, hi);
    run_period(-1, 0, hi);
    run_period(-1, 0, hi);
    chk("t4_still_run", 32'(state_out), 2);
    run_period(-1, 0, hi);
    chk("t4_fault_state", 32'(state_out), 3);
    chk("t4_fault_flag", 32'(fault_out), 1);
    run_period(-1, 0, hi);
    chk("t4_fault_pwm", hi, 0);
    kick = 1'b1; tick(); kick = 1'b0; tick();
    chk("t4_kick_keeps", 32'(state_out), 3);
    stop_in = 1; tick();
    chk("t4_ack", 32'(state_out), 0);
    stop_in = 0; tick();
    chk("t4_rearm", 32'(state_out), 1);

    // Kick coinciding with end of period while the watchdog holds 3.
    wait_ps();
    repeat (3) run_period(5, 0, hi);
    chk("t6_run", 32'(state_out), 2);
    run_period(5, 0, hi);
    run_period(-1, 0, hi);
    run_period(-1, 0, hi);
    run_period(19, 0, hi);
    chk("t6_no_fault", 32'(state_out), 2);
    repeat (3) run_period(-1, 0, hi);
    chk("t6_cleared", 32'(state_out), 2);
    run_period(-1, 0, hi);
    chk("t6_late_fault", 32'(state_out), 3);

    // Illegal period faults at once and leaves the shadow period at 20.
    stop_in = 1; tick(); stop_in = 0;
    wait_ps();
    repeat (3) run_period(5, 0, hi);
    chk("t5_run", 32'(state_out), 2);
    repeat (7) tick();
    period_in = 5; tick();
    chk("t5_fault", 32'(state_out), 3);
    chk("t5_fault_flag", 32'(fault_out), 1);
    wait_ps();
    n = 0;
    do begin tick(); n++; end while (period_start !== 1'b1 && n < 40);
    chk("t5_period_held", n, 20);
    repeat (4) tick();
    rst_n = 1'b0; tick();
    chk("t5_rst_pwm", 32'(pwm_out), 0);
    chk("t5_rst_ps", 32'(period_start), 0);
    chk("t5_rst_state", 32'(state_out), 0);
    chk("t5_rst_fault", 32'(fault_out), 0);

    // Random soak against the model.
    rst_n = 1'b1; period_in = 12;
    for (int k = 0; k < 900; k++) begin
      r = $urandom_range(0, 199);
      if (r == 0) period_in = CW'($urandom_range(0, 9));
      else if (r < 40) period_in = CW'($urandom_range(10, 24));
      for (int i = 0; i < 4; i++) duty_in[i] = CW'($urandom_range(0, 30));
      stop_in = ($urandom_range(0, 99) == 0) ? 1 : {$urandom_range(0, 1), 1'b0};
      kick = (k < 600) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 49) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    kick = 1'b0; rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
